// File: rtl/c17_bench_pkg.sv
// Shared types and constants for the buffered c17 benchmark.
// Used by the capture stage, its FIFO and the result checker.
package c17_bench_pkg;

  localparam int C17_LATENCY = 5;

  typedef struct packed {
    logic n23;
    logic n22;
  } c17_res_t;

endpackage

// File: rtl/c17_wave_capture_if.sv
// Result handshake between the capture stage and the checker.
// The capture stage is the master and drives valid and data.
interface c17_wave_capture_if;
  import c17_bench_pkg::*;

  logic     out_valid;
  logic     out_ready;
  c17_res_t out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/c17_capture_fifo.sv
// Synchronous FIFO with circular pointers and an occupancy count.
// A pop and a push in the same cycle are allowed even when full.
module c17_capture_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (pop_ok) begin
        rptr <= rptr + PTR_ONE;
      end
      if (push_ok) begin
        mem[wptr] <= din;
        wptr      <= wptr + PTR_ONE;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/c17_wave_capture.sv
// Capture stage for the buffered c17 netlist: token pipe, capture
// FIFO, drop handling and saturating throughput counters.
module c17_wave_capture
  import c17_bench_pkg::*;
#(
  parameter int LATENCY    = C17_LATENCY,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic                          in_n22,
  input  logic                          in_n23,
  input  logic                          clear,
  c17_wave_capture_if.master            res,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [CNT_W-1:0]              wave_cnt,
  output logic [CNT_W-1:0]              drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic     settle;
  logic     push;
  logic     pop;
  logic     drop;
  logic     full;
  logic     empty;
  c17_res_t cand;
  c17_res_t head;

  // The launch cycle itself counts as the first stage of latency.
  if (LATENCY == 1) begin : g_nopipe
    assign settle = in_valid;
  end else begin : g_pipe
    logic [LATENCY-2:0] tok;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tok <= '0;
      end else begin
        tok[0] <= in_valid;
        for (int i = 1; i < LATENCY-1; i++) begin
          tok[i] <= tok[i-1];
        end
      end
    end
    assign settle = tok[LATENCY-2];
  end

  assign cand = '{n23: in_n23, n22: in_n22};
  assign pop  = res.out_valid && res.out_ready;
  assign push = settle && (!full || pop);
  assign drop = settle && !push;

  c17_capture_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(c17_res_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (cand),
    .pop   (pop),
    .dout  (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  assign res.out_valid = !empty;
  assign res.out_data  = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_cnt <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wave_cnt <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push && wave_cnt != CNT_MAX) begin
        wave_cnt <= wave_cnt + CNT_ONE;
      end
      if (drop && drop_cnt != CNT_MAX) begin
        drop_cnt <= drop_cnt + CNT_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
